// File: rtl/interrupt_pkg.sv
// Shared types and constants for the interrupt sequencer: FSM states,
// interrupt sources, hardware vector addresses and push-select codes.
package interrupt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DUMMY1,
        ST_DUMMY2,
        ST_PUSH_PCH,
        ST_PUSH_PCL,
        ST_PUSH_P,
        ST_VEC_LO,
        ST_VEC_HI
    } state_t;

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_RESET,
        SRC_NMI,
        SRC_IRQ,
        SRC_BRK
    } src_t;

    localparam logic [15:0] VEC_NMI_LO   = 16'hFFFA;
    localparam logic [15:0] VEC_NMI_HI   = 16'hFFFB;
    localparam logic [15:0] VEC_RESET_LO = 16'hFFFC;
    localparam logic [15:0] VEC_RESET_HI = 16'hFFFD;
    localparam logic [15:0] VEC_IRQ_LO   = 16'hFFFE;
    localparam logic [15:0] VEC_IRQ_HI   = 16'hFFFF;

    localparam logic [1:0] PUSH_SEL_PCH = 2'd0;
    localparam logic [1:0] PUSH_SEL_PCL = 2'd1;
    localparam logic [1:0] PUSH_SEL_P   = 2'd2;

    // IRQ and BRK share a vector; NONE never reaches a vector state.
    function automatic logic [15:0] vector_addr(input src_t src, input logic hi);
        logic [15:0] addr;
        case (src)
            SRC_RESET: addr = hi ? VEC_RESET_HI : VEC_RESET_LO;
            SRC_NMI:   addr = hi ? VEC_NMI_HI : VEC_NMI_LO;
            default:   addr = hi ? VEC_IRQ_HI : VEC_IRQ_LO;
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/interrupt_priority.sv
// Combinational arbiter: reset > NMI > unmasked IRQ > BRK.
module interrupt_priority
    import interrupt_pkg::*;
(
    input  logic reset_req,
    input  logic nmi_req,
    input  logic irq_req,
    input  logic brk_req,
    input  logic i_flag,
    output src_t source
);

    always_comb begin
        if (reset_req) begin
            source = SRC_RESET;
        end else if (nmi_req) begin
            source = SRC_NMI;
        end else if (irq_req && !i_flag) begin
            source = SRC_IRQ;
        end else if (brk_req) begin
            source = SRC_BRK;
        end else begin
            source = SRC_NONE;
        end
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// 6502-style interrupt entry sequencer: two dummy cycles, three stack pushes,
// two vector fetches. Optional macro INTERRUPT_NMI_HIJACK_EN lets an NMI seen
// during PUSH_P redirect an IRQ/BRK sequence to the NMI vector.
module interrupt_sequencer
    import interrupt_pkg::*;
#(
    parameter logic [7:0] STACK_PAGE = 8'h01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enableFFs,
    input  logic        resetDetected,
    input  logic        nmiGenerated,
    input  logic        irqGenerated,
    input  logic        brkDecoded,
    input  logic        instrBoundary,
    input  logic        iFlag,
    input  logic [7:0]  sp,
    output logic        seqActive,
    output logic [15:0] addrOut,
    output logic        addrValid,
    output logic        readNotWrite,
    output logic [1:0]  pushSel,
    output logic        spDec,
    output logic        loadPCL,
    output logic        loadPCH,
    output logic        setIFlag,
    output logic        bFlagOut,
    output logic        interruptAcknowleged
);

    src_t   arb_src;
    state_t state_reg, state_next;
    src_t   source_reg, source_next;

    interrupt_priority u_priority (
        .reset_req (resetDetected),
        .nmi_req   (nmiGenerated),
        .irq_req   (irqGenerated),
        .brk_req   (brkDecoded),
        .i_flag    (iFlag),
        .source    (arb_src)
    );

    always_comb begin
        state_next  = state_reg;
        source_next = source_reg;
        case (state_reg)
            ST_IDLE: begin
                if (instrBoundary && arb_src != SRC_NONE) begin
                    state_next  = ST_DUMMY1;
                    source_next = arb_src;
                end
            end
            ST_DUMMY1:   state_next = ST_DUMMY2;
            ST_DUMMY2:   state_next = ST_PUSH_PCH;
            ST_PUSH_PCH: state_next = ST_PUSH_PCL;
            ST_PUSH_PCL: state_next = ST_PUSH_P;
            ST_PUSH_P: begin
                state_next = ST_VEC_LO;
`ifdef INTERRUPT_NMI_HIJACK_EN
                if (nmiGenerated && (source_reg == SRC_IRQ || source_reg == SRC_BRK)) begin
                    source_next = SRC_NMI;
                end
`endif
            end
            ST_VEC_LO:   state_next = ST_VEC_HI;
            ST_VEC_HI: begin
                state_next  = ST_IDLE;
                source_next = SRC_NONE;
            end
            default: begin
                state_next  = ST_IDLE;
                source_next = SRC_NONE;
            end
        endcase
        // A reset request pre-empts whatever sequence is in flight.
        if (state_reg != ST_IDLE && resetDetected) begin
            state_next  = ST_DUMMY1;
            source_next = SRC_RESET;
        end
    end

    // Outputs are decoded from the upcoming state so they register alongside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg            <= ST_IDLE;
            source_reg           <= SRC_NONE;
            seqActive            <= 1'b0;
            addrOut              <= 16'h0000;
            addrValid            <= 1'b0;
            readNotWrite         <= 1'b1;
            pushSel              <= PUSH_SEL_PCH;
            spDec                <= 1'b0;
            loadPCL              <= 1'b0;
            loadPCH              <= 1'b0;
            setIFlag             <= 1'b0;
            bFlagOut             <= 1'b0;
            interruptAcknowleged <= 1'b0;
        end else if (enableFFs) begin
            state_reg            <= state_next;
            source_reg           <= source_next;
            seqActive            <= (state_next != ST_IDLE);
            addrOut              <= 16'h0000;
            addrValid            <= 1'b0;
            readNotWrite         <= 1'b1;
            pushSel              <= PUSH_SEL_PCH;
            spDec                <= 1'b0;
            loadPCL              <= 1'b0;
            loadPCH              <= 1'b0;
            setIFlag             <= 1'b0;
            bFlagOut             <= 1'b0;
            interruptAcknowleged <= 1'b0;
            case (state_next)
                ST_PUSH_PCH, ST_PUSH_PCL, ST_PUSH_P: begin
                    addrOut      <= {STACK_PAGE, sp};
                    addrValid    <= 1'b1;
                    spDec        <= 1'b1;
                    readNotWrite <= (source_next == SRC_RESET);
                    if (state_next == ST_PUSH_PCH) begin
                        pushSel <= PUSH_SEL_PCH;
                    end else if (state_next == ST_PUSH_PCL) begin
                        pushSel <= PUSH_SEL_PCL;
                    end else begin
                        pushSel  <= PUSH_SEL_P;
                        bFlagOut <= (source_next == SRC_BRK);
                    end
                end
                ST_VEC_LO: begin
                    addrOut   <= vector_addr(source_next, 1'b0);
                    addrValid <= 1'b1;
                    loadPCL   <= 1'b1;
                end
                ST_VEC_HI: begin
                    addrOut              <= vector_addr(source_next, 1'b1);
                    addrValid            <= 1'b1;
                    loadPCH              <= 1'b1;
                    setIFlag             <= 1'b1;
                    interruptAcknowleged <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Randomized bench for interrupt_sequencer with a cycle-table reference model.
// Build with INTERRUPT_NMI_HIJACK_EN defined to check the NMI hijack variant.
module tb_interrupt_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enableFFs;
    logic        resetDetected, nmiGenerated, irqGenerated, brkDecoded;
    logic        instrBoundary, iFlag;
    logic [7:0]  sp;
    logic        seqActive, addrValid, readNotWrite, spDec;
    logic        loadPCL, loadPCH, setIFlag, bFlagOut, interruptAcknowleged;
    logic [1:0]  pushSel;
    logic [15:0] addrOut;

    int vectors = 0;
    int miscompares = 0;

    // Sources as plain numbers: 0 none, 1 reset, 2 nmi, 3 irq, 4 brk.
    localparam logic [26:0] IDLE_W = {3'b001, 24'h000000};

    interrupt_sequencer #(.STACK_PAGE(8'h01)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .enableFFs            (enableFFs),
        .resetDetected        (resetDetected),
        .nmiGenerated         (nmiGenerated),
        .irqGenerated         (irqGenerated),
        .brkDecoded           (brkDecoded),
        .instrBoundary        (instrBoundary),
        .iFlag                (iFlag),
        .sp                   (sp),
        .seqActive            (seqActive),
        .addrOut              (addrOut),
        .addrValid            (addrValid),
        .readNotWrite         (readNotWrite),
        .pushSel              (pushSel),
        .spDec                (spDec),
        .loadPCL              (loadPCL),
        .loadPCH              (loadPCH),
        .setIFlag             (setIFlag),
        .bFlagOut             (bFlagOut),
        .interruptAcknowleged (interruptAcknowleged)
    );

    always #5 clk = ~clk;

    function automatic logic [26:0] obs();
        return {seqActive, addrValid, readNotWrite, pushSel, spDec, loadPCL,
                loadPCH, setIFlag, bFlagOut, interruptAcknowleged, addrOut};
    endfunction

    // Expected output word for cycle k (1..7) after the start cycle.
    function automatic logic [26:0] exp_word(input int src, input int vsrc, input int k,
                                             input logic [7:0] spv);
        logic [15:0] vlo;
        logic        rnw, bf;
        logic [1:0]  ps;
        vlo = (vsrc == 1) ? 16'hFFFC : (vsrc == 2) ? 16'hFFFA : 16'hFFFE;
        rnw = (src == 1);
        bf  = (k == 5) && (src == 4);
        ps  = 2'(k - 3);
        if (k <= 2)
            return {3'b101, 24'h000000};
        if (k <= 5)
            return {1'b1, 1'b1, rnw, ps, 1'b1, 1'b0, 1'b0, 1'b0, bf, 1'b0, 8'h01, spv};
        if (k == 6)
            return {1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, vlo};
        return {1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, vlo + 16'd1};
    endfunction

    task automatic check(input string tag, input logic [26:0] got, input logic [26:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input int id, input bit r, input bit n, input bit q, input bit b,
                           input bit iflg, input logic [7:0] spv, input int stall_k,
                           input int stall_n, input bit late_nmi, input bit abort_rst,
                           input bit hard_rst);
        int  src, vsrc, k;
        bit  abort_pending;
        src = r ? 1 : n ? 2 : (q && !iflg) ? 3 : b ? 4 : 0;
        sp = spv; iFlag = iflg; enableFFs = 1'b1;
        resetDetected = r; nmiGenerated = n; irqGenerated = q; brkDecoded = b;
        instrBoundary = 1'b1;
        step();
        resetDetected = 0; nmiGenerated = 0; irqGenerated = 0; brkDecoded = 0;
        instrBoundary = 1'b0;
        if (src == 0) begin
            check("no_request", obs(), IDLE_W);
            step();
            check("no_request_hold", obs(), IDLE_W);
            $display("txn %0d: no request (r%0d n%0d q%0d b%0d i%0d)", id, r, n, q, b, iflg);
            return;
        end
        vsrc = src; k = 1; abort_pending = abort_rst;
        check("seq_start", obs(), exp_word(src, vsrc, k, spv));
        while (k < 7) begin
            if (k == stall_k) begin
                for (int s = 0; s < stall_n; s++) begin
                    enableFFs = 1'b0;
                    step();
                    check("stall_frozen", obs(), exp_word(src, vsrc, k, spv));
                end
                enableFFs = 1'b1;
            end
            if (hard_rst && k == 6) begin
                enableFFs = 1'b0;
                #2 rst = 1'b1;
                #1 check("async_rst", obs(), IDLE_W);
                enableFFs = 1'b1;
                step();
                check("rst_held", obs(), IDLE_W);
                rst = 1'b0;
                step();
                check("after_rst_idle", obs(), IDLE_W);
                $display("txn %0d: src %0d reset in VEC_LO, sequence discarded", id, src);
                return;
            end
            if (late_nmi && k == 5) nmiGenerated = 1'b1;
            if (abort_pending && k == 4) resetDetected = 1'b1;
            step();
            nmiGenerated = 1'b0;
            resetDetected = 1'b0;
            if (abort_pending && k == 4) begin
                abort_pending = 0;
                src = 1; vsrc = 1; k = 1;
            end else begin
`ifdef INTERRUPT_NMI_HIJACK_EN
                if (late_nmi && k == 5 && (src == 3 || src == 4)) vsrc = 2;
`endif
                k++;
            end
            check("seq_cycle", obs(), exp_word(src, vsrc, k, spv));
        end
        step();
        check("seq_end_idle", obs(), IDLE_W);
        $display("txn %0d: src %0d vector src %0d sp %02h stall@%0d x%0d", id, src, vsrc, spv,
                 stall_k, stall_n);
    endtask

    initial begin
        rst = 1'b1; enableFFs = 1'b0; resetDetected = 0; nmiGenerated = 0;
        irqGenerated = 0; brkDecoded = 0; instrBoundary = 0; iFlag = 0; sp = 8'hFF;
        step();
        step();
        check("reset_state", obs(), IDLE_W);
        rst = 1'b0;
        enableFFs = 1'b1;
        step();
        check("post_reset_idle", obs(), IDLE_W);

        run_txn(0, 1, 0, 0, 0, 0, 8'hFD, 0, 0, 0, 0, 0);
        run_txn(1, 0, 0, 1, 0, 1, 8'hF0, 0, 0, 0, 0, 0);
        run_txn(2, 0, 0, 1, 0, 0, 8'hF0, 0, 0, 0, 0, 0);
        run_txn(3, 0, 1, 1, 0, 0, 8'hE7, 0, 0, 0, 0, 0);
        run_txn(4, 0, 0, 0, 1, 1, 8'h80, 0, 0, 1, 0, 0);
        run_txn(5, 0, 0, 1, 0, 0, 8'h42, 4, 3, 0, 0, 0);
        run_txn(6, 0, 0, 1, 0, 0, 8'h42, 0, 0, 0, 0, 1);
        run_txn(7, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0);
        run_txn(8, 0, 0, 0, 0, 0, 8'h33, 0, 0, 0, 0, 0);
        run_txn(9, 0, 0, 1, 0, 0, 8'h55, 0, 0, 0, 1, 0);

        for (int t = 10; t < 80; t++) begin
            run_txn(t, ($urandom_range(5) == 0), ($urandom_range(3) == 0),
                    ($urandom_range(1) == 0), ($urandom_range(2) == 0),
                    ($urandom_range(1) == 0), 8'($urandom),
                    int'($urandom_range(6, 2)), int'($urandom_range(3)),
                    ($urandom_range(3) == 0), ($urandom_range(7) == 0),
                    ($urandom_range(9) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/interrupt_sequencer.md
INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 SHALL have parameter STACK_PAGE, default 8'h01, high address byte for stack cycles.
REQ-002 SHALL have port clk, input, 1, single system clock, rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port enableFFs, input, 1, global clock enable; state advances only when high.
REQ-005 SHALL have ports resetDetected, nmiGenerated, irqGenerated, input, 1 each, pending-event flags.
REQ-006 SHALL have port brkDecoded, input, 1, BRK opcode present in the instruction register.
REQ-007 SHALL have port instrBoundary, input, 1, high in the cycle the next opcode would be fetched.
REQ-008 SHALL have port iFlag, input, 1, processor status I flag.
REQ-009 SHALL have port sp, input, 8, current stack pointer.
REQ-010 SHALL have ports seqActive (1), addrOut (16), addrValid (1), readNotWrite (1), pushSel (2: 0 PCH, 1 PCL, 2 P), spDec (1), loadPCL (1), loadPCH (1), setIFlag (1), bFlagOut (1), interruptAcknowleged (1), all outputs.

Function
REQ-011 SHALL arbitrate at an enabled instrBoundary cycle with priority resetDetected > nmiGenerated > irqGenerated&&!iFlag > brkDecoded; the winner is latched as source.
REQ-012 SHALL run states IDLE -> DUMMY1 -> DUMMY2 -> PUSH_PCH -> PUSH_PCL -> PUSH_P -> VEC_LO -> VEC_HI -> IDLE, one state per enabled cycle, i.e. 7 cycles after the start cycle.
REQ-013 SHALL hold all state and outputs when enableFFs is low.
REQ-014 SHALL drive addrOut={STACK_PAGE,sp}, spDec=1 and addrValid=1 in each PUSH_* state, with pushSel matching the state.
REQ-015 SHALL assert readNotWrite=0 in PUSH_* states, except for source reset, where readNotWrite=1 and spDec is still asserted.
REQ-016 SHALL drive addrOut in VEC_LO/VEC_HI to the vector low/high byte: reset FFFC/FFFD, NMI FFFA/FFFB, IRQ and BRK FFFE/FFFF; loadPCL in VEC_LO, loadPCH in VEC_HI.
REQ-017 SHALL drive bFlagOut=1 in PUSH_P only for source BRK.
REQ-018 SHALL pulse setIFlag and interruptAcknowleged for exactly one enabled cycle in VEC_HI.
REQ-019 SHALL assert seqActive in every non-IDLE state.
REQ-020 SHALL ignore new arbitration while seqActive; pending flags are left to the injector.
REQ-021 SHALL abort any running sequence on resetDetected and enter DUMMY1 with source reset on the next enabled cycle.
REQ-022 SHALL form the stack address from sp as given; sp=8'h00 yields 16'h0100, and wrap is the stack-pointer owner's job.
REQ-023 SHALL start no sequence and keep outputs at reset values when no request is present at instrBoundary.

Reset
REQ-024 SHALL on rst force state IDLE and source none, with all outputs 0 except readNotWrite=1 and addrOut=16'h0000.
REQ-025 SHALL take effect on assertion independent of clk and enableFFs, with rst mid-sequence discarding the sequence without any acknowledge.

Configuration
REQ-026 SHALL support macro INTERRUPT_NMI_HIJACK_EN; when defined, nmiGenerated high in an enabled PUSH_P cycle of an IRQ/BRK sequence switches the vector to NMI (bFlagOut unchanged).
REQ-027 SHALL, with INTERRUPT_NMI_HIJACK_EN undefined, use the vector chosen at start; a late NMI is serviced after the sequence completes.

Structure
REQ-028 SHALL import package interrupt_pkg holding the state enum, source enum (NONE, RESET, NMI, IRQ, BRK) and the six vector address constants.
REQ-029 SHALL place arbitration in combinational sub-module interrupt_priority (requests plus iFlag -> source).

Verification
REQ-030 SHALL cover: rst release, resetDetected=1 at instrBoundary, sp=8'hFD -> 3 read stack cycles at 01FD (spDec each), then FFFC, FFFD, ack at cycle 7.
REQ-031 SHALL cover: irqGenerated=1, iFlag=1, instrBoundary -> stays IDLE; with iFlag=0 -> writes PCH, PCL, P, then FFFE/FFFF, bFlagOut=0.
REQ-032 SHALL cover: nmiGenerated and irqGenerated both high with iFlag=0 -> vector FFFA/FFFB.
REQ-033 SHALL cover: brkDecoded with nmiGenerated rising in PUSH_P -> FFFA with INTERRUPT_NMI_HIJACK_EN defined, FFFE without, bFlagOut=1 in both.
REQ-034 SHALL cover: enableFFs low for 3 cycles in PUSH_PCL -> outputs frozen, sequence resumes with total enabled length 7.
REQ-035 SHALL cover: rst asserted in VEC_LO -> immediate IDLE, interruptAcknowleged never pulses.
